ucomb_scan: RTL

Serial stimulus loader and response sampler that sits directly upstream and downstream of ucomb_full.
- Shifts a 27-bit stimulus word in one bit at a time from a narrow pad interface, then applies it in parallel to ucomb_full.in.
- Waits a programmable settle time, captures the 6-bit ucomb_full.out, and shifts the result back out serially.
- Lets the unigate combinational fabric, including its reference mode, be exercised from a few I/O pins.

---
 rtl/ucomb_pkg.sv | 17 +
 rtl/ucomb_scan_shreg.sv | 38 +++
 rtl/ucomb_scan.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ucomb_pkg.sv
// Shared widths, FSM states and bench constants for the ucomb scan wrapper.
package ucomb_pkg;

    localparam int unsigned UCOMB_IN_W  = 27;
    localparam int unsigned UCOMB_OUT_W = 6;

    // Low nibble that, together with in[26], selects the fabric reference mode.
    localparam logic [3:0] REFMODE_KEY = 4'b0011;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETTLE    = 2'd1,
        SHIFT_OUT = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/ucomb_scan_shreg.sv
// Serial-in shift register with a saturating count of bits received.
module ucomb_scan_shreg #(
    parameter int unsigned WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             sdi,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] shreg,
    output logic             full_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] bit_cnt;

    assign full_c = (bit_cnt == CNT_W'(WIDTH));

    // Shift MSB-first; extra bits push the oldest ones out, count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            if (shift_en) begin
                shreg <= {shreg[WIDTH-2:0], sdi};
                if (!full_c) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
            if (cnt_clr) begin
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ucomb_scan.sv
// Serial loader / sampler around ucomb_full: shift stimulus in, apply, wait, capture, shift out.
module ucomb_scan
    import ucomb_pkg::*;
#(
    parameter int unsigned WIDTH_IN      = UCOMB_IN_W,
    parameter int unsigned WIDTH_OUT     = UCOMB_OUT_W,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 sdi,
    input  logic                 sdi_valid,
    input  logic                 load,
    output logic [WIDTH_IN-1:0]  stim_out,
    input  logic [WIDTH_OUT-1:0] resp_in,
    output logic                 sdo,
    output logic                 sdo_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 load_err
);

    localparam int unsigned SCNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int unsigned OCNT_W = (WIDTH_OUT > 1) ? $clog2(WIDTH_OUT) : 1;

    state_t               state, state_nx;
    logic [SCNT_W-1:0]    scnt, scnt_nx;
    logic [OCNT_W-1:0]    ocnt, ocnt_nx;
    logic [OCNT_W-1:0]    idx;
    logic [WIDTH_OUT-1:0] resp_reg, resp_nx;
    logic [WIDTH_IN-1:0]  stim_nx;
    logic [WIDTH_IN-1:0]  shreg;
    logic                 full_c;
    logic                 shift_en;
    logic                 cnt_clr;
    logic                 err_nx;
    logic                 sdo_nx;

    ucomb_scan_shreg #(
        .WIDTH (WIDTH_IN)
    ) u_shreg (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .shift_en (shift_en),
        .sdi      (sdi),
        .cnt_clr  (cnt_clr),
        .shreg    (shreg),
        .full_c   (full_c)
    );

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_nx = state;
        scnt_nx  = scnt;
        ocnt_nx  = ocnt;
        resp_nx  = resp_reg;
        stim_nx  = stim_out;
        shift_en = 1'b0;
        cnt_clr  = 1'b0;
        err_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (load) begin
                    if (full_c) begin
                        stim_nx  = shreg;
                        scnt_nx  = SCNT_W'(SETTLE_CYCLES);
                        state_nx = SETTLE;
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (sdi_valid) begin
                    shift_en = 1'b1;
                end
            end
            SETTLE: begin
                if (scnt != '0) begin
                    scnt_nx = scnt - SCNT_W'(1);
                end else begin
                    resp_nx  = resp_in;
                    ocnt_nx  = '0;
                    state_nx = SHIFT_OUT;
                end
            end
            SHIFT_OUT: begin
                if (ocnt == OCNT_W'(WIDTH_OUT - 1)) begin
                    state_nx = DONE;
                end else begin
                    ocnt_nx = ocnt + OCNT_W'(1);
                end
            end
            DONE: begin
                cnt_clr  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        idx    = OCNT_W'(WIDTH_OUT - 1) - ocnt_nx;
        sdo_nx = (state_nx == SHIFT_OUT) ? resp_nx[idx] : 1'b0;
    end

    // State, datapath and output registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            scnt      <= '0;
            ocnt      <= '0;
            resp_reg  <= '0;
            stim_out  <= '0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            scnt      <= scnt_nx;
            ocnt      <= ocnt_nx;
            resp_reg  <= resp_nx;
            stim_out  <= stim_nx;
            sdo       <= sdo_nx;
            sdo_valid <= (state_nx == SHIFT_OUT);
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
            load_err  <= err_nx;
        end
    end

endmodule
